// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32I decode stage: datapath defaults, major
// opcode constants, and the encodings used for immediate format selection,
// ALU operation selection and write-back result selection.
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_pkg;

   // Datapath width and architectural register count used as defaults
   localparam int XLEN_DEFAULT  = 32;
   localparam int NREGS_DEFAULT = 32;

   // Major opcodes understood by the decoder; anything else decodes as a NOP
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Which bit-field layout the immediate extender uses
   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } immSrc_t;

   // What the write-back stage will select as the result
   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } resultSrc_t;

   // Operation code handed to the execute-stage ALU
   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } aluCtl_t;

   // Maps funct3 of an R/I arithmetic instruction onto an ALU operation.
   // subSel is only ever true for register-register adds with funct7[5] set,
   // since the immediate form has no subtract.
   function automatic aluCtl_t aluFromFunct3(input logic [2:0] funct3,
                                             input logic       subSel);
      aluCtl_t op;
      case (funct3)
         3'b000:  op = subSel ? ALU_SUB : ALU_ADD;
         3'b010:  op = ALU_SLT;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// Architectural integer register file: two combinational read ports and one
// write port committed on the rising clock edge. x0 is hardwired to zero and
// a write to the register being read is forwarded in the same cycle.
// Ports:
//   clk, rst        clock and asynchronous active-high reset (clears all regs)
//   i_rs1, i_rs2    read addresses
//   i_we            write enable
//   i_rd            write address
//   i_wd            write data
//   o_rd1, o_rd2    read data
// ---------------------------------------------------------------------------
module register_file
   import riscv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int NREGS = NREGS_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      i_rs1,
   input  logic [4:0]      i_rs2,
   input  logic            i_we,
   input  logic [4:0]      i_rd,
   input  logic [XLEN-1:0] i_wd,
   output logic [XLEN-1:0] o_rd1,
   output logic [XLEN-1:0] o_rd2
);

   logic [XLEN-1:0] r_regs [NREGS];
   logic            w_commit;

   // A write only counts when enabled and not aimed at x0
   assign w_commit = i_we && (i_rd != 5'd0);

   // Storage: reset wipes every register, otherwise commit write-back data.
   // x0 is never written so it stays zero from reset onwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_commit) begin
         r_regs[i_rd] <= i_wd;
      end
   end

   // Read ports: x0 reads zero, and a write landing on the same register this
   // cycle is forwarded so the decode stage sees the value being written.
   always_comb begin
      o_rd1 = r_regs[i_rs1];
      o_rd2 = r_regs[i_rs2];
      if (i_rs1 == 5'd0) begin
         o_rd1 = '0;
      end else if (w_commit && (i_rd == i_rs1)) begin
         o_rd1 = i_wd;
      end
      if (i_rs2 == 5'd0) begin
         o_rd2 = '0;
      end else if (w_commit && (i_rd == i_rs2)) begin
         o_rd2 = i_wd;
      end
   end

endmodule

// File: rtl/decode_cycle.sv
// ---------------------------------------------------------------------------
// decode_cycle
// Decode stage of the five-stage RV32I pipeline. Turns the IF/ID instruction
// into control signals, reads operands from the register file, extends the
// immediate, and registers all of it into the ID/EX pipeline register.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   InstrD, PCD, PCPlus4D    instruction and PC values from IF/ID
//   RegWriteW, RDW, ResultW  register-file write port from write-back
//   FlushE                   insert a bubble into ID/EX on the next edge
//   Rs1D, Rs2D               combinational source fields for hazard logic
//   *E outputs               registered ID/EX contents for execute
// ---------------------------------------------------------------------------
module decode_cycle
   import riscv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int NREGS = NREGS_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            RegWriteW,
   input  logic [4:0]      RDW,
   input  logic [XLEN-1:0] ResultW,
   input  logic            FlushE,
   output logic [4:0]      Rs1D,
   output logic [4:0]      Rs2D,
   output logic            RegWriteE,
   output logic            MemWriteE,
   output logic            JumpE,
   output logic            BranchE,
   output logic            ALUSrcE,
   output logic [1:0]      ResultSrcE,
   output logic [2:0]      ALUControlE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [4:0]      RDE,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E
);

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic            w_subSel;
   logic            w_regWrite;
   logic            w_memWrite;
   logic            w_jump;
   logic            w_branch;
   logic            w_aluSrc;
   resultSrc_t      w_resultSrc;
   immSrc_t         w_immSrc;
   aluCtl_t         w_aluCtl;
   logic [XLEN-1:0] w_immExt;
   logic [XLEN-1:0] w_rd1;
   logic [XLEN-1:0] w_rd2;

   assign w_opcode = InstrD[6:0];
   assign w_funct3 = InstrD[14:12];
   assign Rs1D     = InstrD[19:15];
   assign Rs2D     = InstrD[24:20];

   // Subtract is chosen only for the register-register form (opcode bit 5)
   // with funct7 bit 5 set; the immediate form always adds.
   assign w_subSel = w_opcode[5] & InstrD[30];

   register_file #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_registerFile (
      .clk   (clk),
      .rst   (rst),
      .i_rs1 (Rs1D),
      .i_rs2 (Rs2D),
      .i_we  (RegWriteW),
      .i_rd  (RDW),
      .i_wd  (ResultW),
      .o_rd1 (w_rd1),
      .o_rd2 (w_rd2)
   );

   // Main control decoder. Every control starts at zero so an unknown opcode
   // falls through as a harmless NOP rather than trapping.
   always_comb begin
      w_regWrite  = 1'b0;
      w_memWrite  = 1'b0;
      w_jump      = 1'b0;
      w_branch    = 1'b0;
      w_aluSrc    = 1'b0;
      w_resultSrc = RES_ALU;
      w_immSrc    = IMM_I;
      w_aluCtl    = ALU_ADD;
      case (w_opcode)
         OP_LOAD: begin
            w_regWrite  = 1'b1;
            w_aluSrc    = 1'b1;
            w_resultSrc = RES_MEM;
         end
         OP_STORE: begin
            w_memWrite = 1'b1;
            w_aluSrc   = 1'b1;
            w_immSrc   = IMM_S;
         end
         OP_RTYPE: begin
            w_regWrite = 1'b1;
            w_aluCtl   = aluFromFunct3(w_funct3, w_subSel);
         end
         OP_ITYPE: begin
            w_regWrite = 1'b1;
            w_aluSrc   = 1'b1;
            w_aluCtl   = aluFromFunct3(w_funct3, w_subSel);
         end
         OP_BRANCH: begin
            w_branch = 1'b1;
            w_aluCtl = ALU_SUB;
            w_immSrc = IMM_B;
         end
         OP_JAL: begin
            w_regWrite  = 1'b1;
            w_jump      = 1'b1;
            w_resultSrc = RES_PC4;
            w_immSrc    = IMM_J;
         end
         default: begin
         end
      endcase
   end

   // Immediate extender: reassemble the scattered immediate bits for the
   // selected format and sign-extend from instruction bit 31.
   always_comb begin
      w_immExt = '0;
      case (w_immSrc)
         IMM_I:   w_immExt = {{20{InstrD[31]}}, InstrD[31:20]};
         IMM_S:   w_immExt = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B:   w_immExt = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                              InstrD[11:8], 1'b0};
         IMM_J:   w_immExt = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20],
                              InstrD[30:21], 1'b0};
         default: w_immExt = '0;
      endcase
   end

   // ID/EX pipeline register. Reset and flush both load an all-zero bubble,
   // which the execute stage treats as a NOP; otherwise the freshly decoded
   // instruction is captured every cycle since this stage never stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || FlushE) begin
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ResultSrcE  <= 2'b00;
         ALUControlE <= 3'b000;
         RD1E        <= '0;
         RD2E        <= '0;
         ImmExtE     <= '0;
         RDE         <= 5'd0;
         Rs1E        <= 5'd0;
         Rs2E        <= 5'd0;
         PCE         <= '0;
         PCPlus4E    <= '0;
      end else begin
         RegWriteE   <= w_regWrite;
         MemWriteE   <= w_memWrite;
         JumpE       <= w_jump;
         BranchE     <= w_branch;
         ALUSrcE     <= w_aluSrc;
         ResultSrcE  <= w_resultSrc;
         ALUControlE <= w_aluCtl;
         RD1E        <= w_rd1;
         RD2E        <= w_rd2;
         ImmExtE     <= w_immExt;
         RDE         <= InstrD[11:7];
         Rs1E        <= Rs1D;
         Rs2E        <= Rs2D;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
      end
   end

endmodule

// File: tb/tb_decode_cycle.sv
// ---------------------------------------------------------------------------
// tb_decode_cycle
// Self-checking bench for decode_cycle. A driver issues directed and random
// instructions plus write-back traffic; for each issued cycle a reference
// model predicts the ID/EX contents and queues them. A monitor compares the
// queued prediction against the E outputs after every rising edge.
// ---------------------------------------------------------------------------
module tb_decode_cycle;

   logic        clk;
   logic        rst;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        RegWriteW;
   logic [4:0]  RDW;
   logic [31:0] ResultW;
   logic        FlushE;
   logic [4:0]  Rs1D;
   logic [4:0]  Rs2D;
   logic        RegWriteE;
   logic        MemWriteE;
   logic        JumpE;
   logic        BranchE;
   logic        ALUSrcE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E;
   logic [31:0] RD2E;
   logic [31:0] ImmExtE;
   logic [4:0]  RDE;
   logic [4:0]  Rs1E;
   logic [4:0]  Rs2E;
   logic [31:0] PCE;
   logic [31:0] PCPlus4E;

   // Predicted ID/EX contents; ctrl is
   // {RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc[1:0], ALUControl[2:0]}
   typedef struct packed {
      logic [9:0]  ctrl;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [14:0] fields;
      logic [31:0] pc;
      logic [31:0] pc4;
   } expT;

   expT         scoreQ[$];
   logic [31:0] modelRegs [32];
   int          checks   = 0;
   int          failures = 0;
   logic        driveDone = 1'b0;

   decode_cycle dut (
      .clk         (clk),
      .rst         (rst),
      .InstrD      (InstrD),
      .PCD         (PCD),
      .PCPlus4D    (PCPlus4D),
      .RegWriteW   (RegWriteW),
      .RDW         (RDW),
      .ResultW     (ResultW),
      .FlushE      (FlushE),
      .Rs1D        (Rs1D),
      .Rs2D        (Rs2D),
      .RegWriteE   (RegWriteE),
      .MemWriteE   (MemWriteE),
      .JumpE       (JumpE),
      .BranchE     (BranchE),
      .ALUSrcE     (ALUSrcE),
      .ResultSrcE  (ResultSrcE),
      .ALUControlE (ALUControlE),
      .RD1E        (RD1E),
      .RD2E        (RD2E),
      .ImmExtE     (ImmExtE),
      .RDE         (RDE),
      .Rs1E        (Rs1E),
      .Rs2E        (Rs2E),
      .PCE         (PCE),
      .PCPlus4E    (PCPlus4E)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: every check goes through here
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Register read as seen by decode: x0 is zero, a same-cycle write wins
   function automatic logic [31:0] modelRead(input logic [4:0] a,
                                             input logic we,
                                             input logic [4:0] wa,
                                             input logic [31:0] wd);
      if (a == 5'd0) return 32'd0;
      if (we && (wa == a)) return wd;
      return modelRegs[a];
   endfunction

   // ALU operation chosen by funct3 for arithmetic instructions
   function automatic logic [2:0] modelAlu(input logic [2:0] f3,
                                           input logic isSub);
      case (f3)
         3'd0:    return isSub ? 3'b001 : 3'b000;
         3'd2:    return 3'b101;
         3'd6:    return 3'b011;
         3'd7:    return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Reference model of what ID/EX should hold after the edge
   function automatic expT modelDecode(input logic [31:0] instr,
                                       input logic [31:0] pc,
                                       input logic flush,
                                       input logic we,
                                       input logic [4:0] wa,
                                       input logic [31:0] wd);
      expT         e;
      logic        rw, mw, j, b, as;
      logic [1:0]  rs;
      logic [2:0]  alu;
      logic [31:0] immI, immS, immB, immJ, imm;
      immI = {{20{instr[31]}}, instr[31:20]};
      immS = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      immB = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      immJ = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      rw = 0; mw = 0; j = 0; b = 0; as = 0; rs = 2'b00; alu = 3'b000; imm = immI;
      case (instr[6:0])
         7'b0000011: begin rw = 1; as = 1; rs = 2'b01; end
         7'b0100011: begin mw = 1; as = 1; imm = immS; end
         7'b0110011: begin rw = 1; alu = modelAlu(instr[14:12], instr[30]); end
         7'b0010011: begin rw = 1; as = 1; alu = modelAlu(instr[14:12], 1'b0); end
         7'b1100011: begin b = 1; alu = 3'b001; imm = immB; end
         7'b1101111: begin rw = 1; j = 1; rs = 2'b10; imm = immJ; end
         default: ;
      endcase
      e = '0;
      if (!flush) begin
         e.ctrl   = {rw, mw, j, b, as, rs, alu};
         e.rd1    = modelRead(instr[19:15], we, wa, wd);
         e.rd2    = modelRead(instr[24:20], we, wa, wd);
         e.imm    = imm;
         e.fields = {instr[11:7], instr[19:15], instr[24:20]};
         e.pc     = pc;
         e.pc4    = pc + 32'd4;
      end
      return e;
   endfunction

   // Drive one cycle's inputs at the current (falling) edge and queue the
   // prediction; the model's register state commits the write-back.
   task automatic driveNow(input logic [31:0] instr, input logic [31:0] pc,
                           input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic flush);
      InstrD    = instr;
      PCD       = pc;
      PCPlus4D  = pc + 32'd4;
      RegWriteW = we;
      RDW       = wa;
      ResultW   = wd;
      FlushE    = flush;
      scoreQ.push_back(modelDecode(instr, pc, flush, we, wa, wd));
      if (we && (wa != 5'd0)) modelRegs[wa] = wd;
      #1;
      checkOutput("Rs1D", {27'd0, Rs1D}, {27'd0, instr[19:15]});
      checkOutput("Rs2D", {27'd0, Rs2D}, {27'd0, instr[24:20]});
   endtask

   task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic flush);
      @(negedge clk);
      driveNow(instr, pc, we, wa, wd, flush);
   endtask

   // Every E output must be zero while reset is held
   task automatic checkAllZero(input string tag);
      checkOutput({tag, "Ctrl"}, {22'd0, RegWriteE, MemWriteE, JumpE, BranchE,
                  ALUSrcE, ResultSrcE, ALUControlE}, 32'd0);
      checkOutput({tag, "RD1E"}, RD1E, 32'd0);
      checkOutput({tag, "RD2E"}, RD2E, 32'd0);
      checkOutput({tag, "ImmExtE"}, ImmExtE, 32'd0);
      checkOutput({tag, "Fields"}, {17'd0, RDE, Rs1E, Rs2E}, 32'd0);
      checkOutput({tag, "PCE"}, PCE, 32'd0);
      checkOutput({tag, "PCPlus4E"}, PCPlus4E, 32'd0);
   endtask

   // Mid-run reset: assert between edges, verify clearing, release so the
   // very next edge captures a freshly driven instruction.
   task automatic doReset();
      @(negedge clk);
      rst       = 1'b1;
      RegWriteW = 1'b0;
      FlushE    = 1'b0;
      #1;
      checkAllZero("midRst");
      for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
      @(negedge clk);
      checkAllZero("midRstHeld");
      rst = 1'b0;
      driveNow(32'h000283B3, 32'h0000_0200, 1'b0, 5'd0, 32'd0, 1'b0);
   endtask

   // Monitor: after each rising edge, compare ID/EX to the oldest prediction
   initial begin
      expT e;
      forever begin
         @(posedge clk);
         #1;
         if (scoreQ.size() > 0) begin
            e = scoreQ.pop_front();
            checkOutput("ctrl", {22'd0, RegWriteE, MemWriteE, JumpE, BranchE,
                        ALUSrcE, ResultSrcE, ALUControlE}, {22'd0, e.ctrl});
            checkOutput("RD1E", RD1E, e.rd1);
            checkOutput("RD2E", RD2E, e.rd2);
            checkOutput("ImmExtE", ImmExtE, e.imm);
            checkOutput("RDE/Rs1E/Rs2E", {17'd0, RDE, Rs1E, Rs2E}, {17'd0, e.fields});
            checkOutput("PCE", PCE, e.pc);
            checkOutput("PCPlus4E", PCPlus4E, e.pc4);
         end
      end
   end

   // Driver: directed scenarios first, then randomized traffic
   initial begin
      logic [6:0]  opList [6];
      logic [31:0] r;
      logic [6:0]  op;
      logic [31:0] instr;
      logic        we;
      logic [4:0]  wa;
      opList = '{7'b0000011, 7'b0100011, 7'b0110011,
                 7'b0010011, 7'b1100011, 7'b1101111};
      for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;

      rst       = 1'b1;
      InstrD    = 32'h00A00293;
      PCD       = 32'd0;
      PCPlus4D  = 32'd0;
      RegWriteW = 1'b0;
      RDW       = 5'd0;
      ResultW   = 32'd0;
      FlushE    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkAllZero("rst");
      rst = 1'b0;

      // addi x5,x0,10
      driveNow(32'h00A00293, 32'h100, 1'b0, 5'd0, 32'd0, 1'b0);
      // add x7,x5,x0: x5 still holds its reset value
      applyStimulus(32'h000283B3, 32'h104, 1'b0, 5'd0, 32'd0, 1'b0);
      // add x6,x5,x5 with write-back of x5 in the same cycle
      applyStimulus(32'h00528333, 32'h108, 1'b1, 5'd5, 32'h00001234, 1'b0);
      // attempted write of x0, then add x1,x0,x0
      applyStimulus(32'h00000013, 32'h10C, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
      applyStimulus(32'h000000B3, 32'h110, 1'b0, 5'd0, 32'd0, 1'b0);
      // beq x0,x0,-8
      applyStimulus(32'hFE000CE3, 32'h114, 1'b0, 5'd0, 32'd0, 1'b0);
      // sw x5,4(x2) flushed, with a write-back that must still commit
      applyStimulus(32'h00512223, 32'h118, 1'b1, 5'd2, 32'h00000040, 1'b1);
      applyStimulus(32'h00512223, 32'h118, 1'b0, 5'd0, 32'd0, 1'b0);

      for (int n = 0; n < 600; n++) begin
         if (n == 300) doReset();
         r = $urandom();
         if ($urandom_range(0, 7) < 6) op = opList[$urandom_range(0, 5)];
         else op = r[6:0];
         instr = {r[31:7], op};
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) wa = instr[19:15];
         else wa = 5'($urandom_range(0, 31));
         applyStimulus(instr, $urandom() & 32'hFFFFFFFC, we, wa, $urandom(),
                       ($urandom_range(0, 7) == 0));
      end

      @(posedge clk);
      #2;
      checkOutput("queueDrained", scoreQ.size(), 32'd0);
      driveDone = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Second stage of the five-stage RV32I pipeline. Consumes the fetch stage's IF/ID outputs (InstrD, PCD, PCPlus4D) and decodes the instruction into control signals. Reads the register file and extends the immediate. Registers everything into the ID/EX pipeline register that feeds the execute stage, which later returns PCSrcE/PCTargetE to fetch. Also hosts the register file write port driven by write-back.

## Interface
- XLEN, 32, datapath and register width
- NREGS, 32, architectural register count (x0 hardwired zero)

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- InstrD  in  32  instruction from IF/ID
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- RegWriteW  in  1  write-back enable
- RDW  in  5  write-back destination
- ResultW  in  32  write-back data
- FlushE  in  1  load bubble into ID/EX on next edge
- Rs1D, Rs2D  out  5  source fields of InstrD (combinational, for hazard unit)
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered controls
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RD1E, RD2E  out  32  register operands
- ImmExtE  out  32  sign-extended immediate
- RDE, Rs1E, Rs2E  out  5  register fields
- PCE, PCPlus4E  out  32  forwarded PC values

## Operation
- Opcode decode:
  - lw 0000011: RegWrite, ALUSrc, ResultSrc=01, ImmSrc I.
  - sw 0100011: MemWrite, ALUSrc, ImmSrc S.
  - R 0110011: RegWrite.
  - I-ALU 0010011: RegWrite, ALUSrc, ImmSrc I.
  - beq 1100011: Branch, ALUControl=sub, ImmSrc B.
  - jal 1101111: RegWrite, Jump, ResultSrc=10, ImmSrc J.
  - Any other opcode: all controls 0 (NOP), no trap.
- ALU decode:
  - lw/sw force add.
  - R/I select by funct3: 000 gives add, or sub when opcode[5]&funct7[5]; 010 slt; 110 or; 111 and.
  - Unlisted funct3 gives add.
- Immediate extension is sign-extended from bit 31 for all formats:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- Register file:
  - 32×32.
  - Two combinational read ports, one write port on the rising edge when RegWriteW=1 and RDW≠0.
  - Writes to x0 are ignored; x0 always reads 0.
  - Write-through bypass: if RegWriteW=1, RDW≠0 and RDW equals the read address, the read returns ResultW in the same cycle.
- ID/EX register:
  - Captures all E outputs each rising edge.
  - FlushE=1 loads all-zero (a NOP bubble) instead of the decoded values.

## Timing
- Reset: while rst=1 every E output is 0 and all 32 registers are 0, asynchronously.
- Rs1D and Rs2D are combinational and not reset.
- Latency: decode of InstrD at edge N appears on the E outputs after edge N+1. No stall input; the stage accepts one instruction per cycle.
- FlushE is sampled at the edge. A bubble occupies exactly one cycle.
- A write-back in a FlushE cycle still commits.
- Simultaneous write-back and read of the same register: the new value is seen, via the bypass, and is captured into RD1E/RD2E at that edge.
- Reset asserted mid-operation clears in-flight ID/EX contents and the register file. The first edge after release captures the current InstrD normally.

## Structure
- Package riscv_pkg holds:
  - opcode constants;
  - ImmSrc encoding (I 00, S 01, B 10, J 11);
  - ALUControl encoding and ResultSrc encoding;
  - the XLEN default.
- Sub-module register_file: 32×32 array, async reset, bypass, x0 rule.
- Control decoder, immediate extender and ID/EX register stay inline in decode_cycle.

## Test plan
- Reset: hold rst=1 with InstrD=0x00A00293.
  - All E outputs read 0.
  - After release, a read of x5 returns 0.
- addi x5,x0,10 (0x00A00293), PCD=0x100, then one edge:
  - RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=0x0000000A, RDE=5;
  - PCE=0x100, PCPlus4E=0x104.
- Bypass: RegWriteW=1, RDW=5, ResultW=0x00001234 while decoding add x6,x5,x5 (0x00528333).
  - RD1E=RD2E=0x00001234, RDE=6, ALUSrcE=0.
- x0 write: RegWriteW=1, RDW=0, ResultW=0xFFFFFFFF, then decode add x1,x0,x0.
  - RD1E=RD2E=0.
- beq x0,x0,-8 (0xFE000CE3):
  - BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8, RegWriteE=0.
- Flush: sw x5,4(x2) (0x00512223) with FlushE=1.
  - All E outputs are 0 next cycle; MemWriteE stays 0.
  - The same instruction with FlushE=0 gives MemWriteE=1 and ImmExtE=0x00000004.
